// File: rtl/latch_seq_pkg.sv
// Shared types and constants for the latch gate sequencer.
// State encoding, phase counter width and the preset data pattern.
package latch_seq_pkg;

    typedef enum logic [2:0] {
        ST_PRESET,
        ST_IDLE,
        ST_SETUP,
        ST_GATE,
        ST_HOLD
    } state_e;

    localparam int CNT_W = 4;

    localparam int DATA_W_DFLT = 4;

    localparam logic [DATA_W_DFLT-1:0] ALL_ONES = '1;

endpackage

// File: rtl/latch_gate_sequencer_phase_counter.sv
// Loadable down-counter that times each sequencer phase.
// zero is high once the count has reached 0; it then holds there.
module phase_counter
    import latch_seq_pkg::*;
#(
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Load takes priority, otherwise count down and stop at 0.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register, reset to the post-reset preset length.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/latch_gate_sequencer.sv
// Drives a 4-bit active-low-gated latch with timed setup/gate/hold windows.
// Optional Q read-back checking is enabled with `define LATCH_CHECK_EN.
module latch_gate_sequencer
    import latch_seq_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DFLT,
    parameter int SETUP_CYC = 1,
    parameter int GATE_CYC  = 2,
    parameter int HOLD_CYC  = 1,
    parameter int PRE_CYC   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef LATCH_CHECK_EN
    input  logic [DATA_W-1:0] q_fb,
    output logic              err,
`endif
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              preset_req,
    output logic [DATA_W-1:0] D,
    output logic              G,
    output logic              PRE,
    output logic              busy,
    output logic              done
);

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] GATE_LD  = CNT_W'(GATE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] PRE_LD   = CNT_W'(PRE_CYC - 1);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] d_q, d_d;
    logic              g_q, g_d;
    logic              pre_q, pre_d;
    logic              done_q, done_d;
    logic              pend_q, pend_d;
    logic              ld;
    logic [CNT_W-1:0]  ld_val;
    logic              zero;

    phase_counter #(
        .RST_VAL (PRE_LD)
    ) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (ld),
        .load_val (ld_val),
        .zero     (zero)
    );

    // Next state, registered latch outputs and counter loads.
    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        g_d     = g_q;
        pre_d   = pre_q;
        done_d  = 1'b0;
        pend_d  = pend_q;
        ld      = 1'b0;
        ld_val  = '0;
        if (preset_req && state_q != ST_IDLE) begin
            pend_d = 1'b1;
        end
        unique case (state_q)
            ST_PRESET: begin
                if (zero) begin
                    state_d = ST_IDLE;
                    pre_d   = 1'b0;
                    done_d  = 1'b1;
                end
            end
            ST_IDLE: begin
                if (pend_q || preset_req) begin
                    state_d = ST_PRESET;
                    pre_d   = 1'b1;
                    g_d     = 1'b1;
                    pend_d  = 1'b0;
                    ld      = 1'b1;
                    ld_val  = PRE_LD;
                end else if (in_valid) begin
                    state_d = ST_SETUP;
                    d_d     = in_data;
                    ld      = 1'b1;
                    ld_val  = SETUP_LD;
                end
            end
            ST_SETUP: begin
                if (zero) begin
                    state_d = ST_GATE;
                    g_d     = 1'b0;
                    ld      = 1'b1;
                    ld_val  = GATE_LD;
                end
            end
            ST_GATE: begin
                if (zero) begin
                    state_d = ST_HOLD;
                    g_d     = 1'b1;
                    ld      = 1'b1;
                    ld_val  = HOLD_LD;
                end
            end
            ST_HOLD: begin
                if (zero) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_PRESET;
            end
        endcase
    end

    // State and output registers; reset presets the latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_PRESET;
            d_q     <= '0;
            g_q     <= 1'b1;
            pre_q   <= 1'b1;
            done_q  <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            g_q     <= g_d;
            pre_q   <= pre_d;
            done_q  <= done_d;
            pend_q  <= pend_d;
        end
    end

`ifdef LATCH_CHECK_EN
    localparam logic [DATA_W-1:0] ONES = {DATA_W{1'b1}};

    logic err_q, err_d;

    // Sticky flag when the latch read-back disagrees at phase end.
    always_comb begin
        err_d = err_q;
        if (state_q == ST_HOLD && zero && q_fb != d_q) begin
            err_d = 1'b1;
        end
        if (state_q == ST_PRESET && zero && q_fb != ONES) begin
            err_d = 1'b1;
        end
    end

    // Error register, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`endif

    assign in_ready = (state_q == ST_IDLE) && !pend_q && !preset_req;
    assign busy     = (state_q != ST_IDLE);
    assign D        = d_q;
    assign G        = g_q;
    assign PRE      = pre_q;
    assign done     = done_q;

endmodule
